// File: rtl/pmp_csr_if.sv
// CSR-stage request/response bundle between the pipeline and the PMP CSR file.
interface pmp_csr_if;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic        csr_re;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [1:0]  priv_mode;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        csr_illegal;

  modport master (
    output csr_addr, csr_we, csr_re, csr_op, csr_wdata, priv_mode,
    input  csr_rdata, csr_rvalid, csr_illegal
  );

  modport slave (
    input  csr_addr, csr_we, csr_re, csr_op, csr_wdata, priv_mode,
    output csr_rdata, csr_rvalid, csr_illegal
  );
endinterface

// File: rtl/pmp_csr_file.sv
// M-mode PMP CSR storage (pmpcfg0..3, pmpaddr0..15) with WARL legalisation and
// L-bit locking; stored values drive the PMP checker directly.
module pmp_csr_file #(
  parameter int NUM_ENTRIES = 16,
  parameter bit NA4_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  pmp_csr_if.slave    bus,
  output logic [31:0] pmpcfg0_data,
  output logic [31:0] pmpcfg1_data,
  output logic [31:0] pmpcfg2_data,
  output logic [31:0] pmpcfg3_data,
  output logic [31:0] pmpaddr0_data,
  output logic [31:0] pmpaddr1_data,
  output logic [31:0] pmpaddr2_data,
  output logic [31:0] pmpaddr3_data,
  output logic [31:0] pmpaddr4_data,
  output logic [31:0] pmpaddr5_data,
  output logic [31:0] pmpaddr6_data,
  output logic [31:0] pmpaddr7_data,
  output logic [31:0] pmpaddr8_data,
  output logic [31:0] pmpaddr9_data,
  output logic [31:0] pmpaddr10_data,
  output logic [31:0] pmpaddr11_data,
  output logic [31:0] pmpaddr12_data,
  output logic [31:0] pmpaddr13_data,
  output logic [31:0] pmpaddr14_data,
  output logic [31:0] pmpaddr15_data
);

  logic [7:0]  cfg_q    [16];
  logic [31:0] addr_q   [16];
  logic [31:0] cfg_word [4];
  logic [15:0] addr_lock;

  logic        is_cfg, is_addr, wr_req, access, legal;
  logic [31:0] old_word, cand;

  for (genvar g = 0; g < 4; g++) begin : g_word
    assign cfg_word[g] = {cfg_q[4*g+3], cfg_q[4*g+2], cfg_q[4*g+1], cfg_q[4*g]};
  end

  // pmpaddr i is frozen by its own L bit, or by a locked TOR entry i+1 using it as base.
  for (genvar g = 0; g < 16; g++) begin : g_lock
    if (g < 15) begin : g_tor
      assign addr_lock[g] = cfg_q[g][7] | (cfg_q[g+1][7] & (cfg_q[g+1][4:3] == 2'b01));
    end else begin : g_last
      assign addr_lock[g] = cfg_q[g][7];
    end
  end

  function automatic logic [7:0] legalise_cfg(input logic [7:0] old_b, input logic [7:0] cand_b);
    logic [7:0] nb;
    if (old_b[7]) return old_b;
    nb      = cand_b;
    nb[6:5] = 2'b00;
    if (!cand_b[0] && cand_b[1]) nb[1] = 1'b0;
    if (!NA4_EN && cand_b[4:3] == 2'b10) nb[4:3] = old_b[4:3];
    return nb;
  endfunction

  always_comb begin
    is_cfg   = (bus.csr_addr[11:2] == 10'h0E8);
    is_addr  = (bus.csr_addr[11:4] == 8'h3B);
    wr_req   = bus.csr_we && (bus.csr_op != 2'b00);
    access   = wr_req || bus.csr_re;
    legal    = (is_cfg || is_addr) && (bus.priv_mode == 2'b11);
    old_word = is_cfg ? cfg_word[bus.csr_addr[1:0]] : addr_q[bus.csr_addr[3:0]];
    case (bus.csr_op)
      2'b10:   cand = old_word | bus.csr_wdata;
      2'b11:   cand = old_word & ~bus.csr_wdata;
      default: cand = bus.csr_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < 16; e++) begin
        cfg_q[e]  <= 8'h00;
        addr_q[e] <= 32'h0;
      end
      bus.csr_rdata   <= 32'h0;
      bus.csr_rvalid  <= 1'b0;
      bus.csr_illegal <= 1'b0;
    end else begin
      bus.csr_rvalid  <= access && legal && bus.csr_re;
      bus.csr_illegal <= access && !legal;
      if (access && legal && bus.csr_re) bus.csr_rdata <= old_word;
      // Entries at or above NUM_ENTRIES are never written and so stay hardwired to 0.
      if (wr_req && legal) begin
        for (int e = 0; e < 16; e++) begin
          if (e < NUM_ENTRIES) begin
            if (is_cfg && bus.csr_addr[1:0] == e[3:2])
              cfg_q[e] <= legalise_cfg(cfg_q[e], cand[8*(e%4) +: 8]);
            if (is_addr && bus.csr_addr[3:0] == e[3:0] && !addr_lock[e])
              addr_q[e] <= cand;
          end
        end
      end
    end
  end

  assign pmpcfg0_data   = cfg_word[0];
  assign pmpcfg1_data   = cfg_word[1];
  assign pmpcfg2_data   = cfg_word[2];
  assign pmpcfg3_data   = cfg_word[3];
  assign pmpaddr0_data  = addr_q[0];
  assign pmpaddr1_data  = addr_q[1];
  assign pmpaddr2_data  = addr_q[2];
  assign pmpaddr3_data  = addr_q[3];
  assign pmpaddr4_data  = addr_q[4];
  assign pmpaddr5_data  = addr_q[5];
  assign pmpaddr6_data  = addr_q[6];
  assign pmpaddr7_data  = addr_q[7];
  assign pmpaddr8_data  = addr_q[8];
  assign pmpaddr9_data  = addr_q[9];
  assign pmpaddr10_data = addr_q[10];
  assign pmpaddr11_data = addr_q[11];
  assign pmpaddr12_data = addr_q[12];
  assign pmpaddr13_data = addr_q[13];
  assign pmpaddr14_data = addr_q[14];
  assign pmpaddr15_data = addr_q[15];

endmodule

// File: tb/tb_pmp_csr_file.sv
// Scoreboard bench for pmp_csr_file: directed scenarios, then randomized traffic
// against an array-based reference model of the PMP CSR rules.
module tb_pmp_csr_file;
  localparam bit         NA4 = 1'b1;
  localparam logic [1:0] RW  = 2'b01;
  localparam logic [1:0] RS  = 2'b10;
  localparam logic [1:0] RC  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmp_csr_if bus ();
  logic [31:0] cfg_o  [4];
  logic [31:0] addr_o [16];

  pmp_csr_file #(.NUM_ENTRIES(16), .NA4_EN(NA4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pmpcfg0_data(cfg_o[0]), .pmpcfg1_data(cfg_o[1]),
    .pmpcfg2_data(cfg_o[2]), .pmpcfg3_data(cfg_o[3]),
    .pmpaddr0_data(addr_o[0]),   .pmpaddr1_data(addr_o[1]),
    .pmpaddr2_data(addr_o[2]),   .pmpaddr3_data(addr_o[3]),
    .pmpaddr4_data(addr_o[4]),   .pmpaddr5_data(addr_o[5]),
    .pmpaddr6_data(addr_o[6]),   .pmpaddr7_data(addr_o[7]),
    .pmpaddr8_data(addr_o[8]),   .pmpaddr9_data(addr_o[9]),
    .pmpaddr10_data(addr_o[10]), .pmpaddr11_data(addr_o[11]),
    .pmpaddr12_data(addr_o[12]), .pmpaddr13_data(addr_o[13]),
    .pmpaddr14_data(addr_o[14]), .pmpaddr15_data(addr_o[15])
  );

  typedef struct {
    bit          ill;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       sb [$];
  logic [7:0]  cfg_m  [16];
  logic [31:0] addr_m [16];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] m_cfg(input logic [7:0] old_b, input logic [7:0] c);
    logic       r, w, x, l;
    logic [1:0] a;
    if (old_b[7]) return old_b;
    r = c[0]; w = c[1]; x = c[2]; a = c[4:3]; l = c[7];
    if (!r && w) w = 1'b0;
    if (a == 2'b10 && !NA4) a = old_b[4:3];
    return {l, 2'b00, a, x, w, r};
  endfunction

  function automatic bit m_locked(input int i);
    if (cfg_m[i][7]) return 1'b1;
    if (i == 15) return 1'b0;
    return cfg_m[i+1][7] && (cfg_m[i+1][4:3] == 2'b01);
  endfunction

  // One request per cycle: expectations pushed now, model state applied after the edge.
  task automatic step(input bit r, input bit we, input bit re, input logic [1:0] op,
                      input logic [11:0] a, input logic [31:0] wd, input logic [1:0] pv);
    bit          is_cfg, is_addr, wr, acc, legal;
    int          idx;
    logic [31:0] old, cand;
    logic [7:0]  ncfg  [16];
    logic [31:0] naddr [16];
    rst = r;
    bus.csr_we = we; bus.csr_re = re; bus.csr_op = op;
    bus.csr_addr = a; bus.csr_wdata = wd; bus.priv_mode = pv;
    ncfg = cfg_m; naddr = addr_m;
    is_cfg  = (a >= 12'h3A0) && (a <= 12'h3A3);
    is_addr = (a >= 12'h3B0) && (a <= 12'h3BF);
    idx     = is_cfg ? int'(a) - 32'h3A0 : int'(a) - 32'h3B0;
    wr      = we && (op != 2'b00);
    acc     = wr || re;
    legal   = (is_cfg || is_addr) && (pv == 2'b11);
    old     = 32'h0;
    if (is_cfg) old = {cfg_m[4*idx+3], cfg_m[4*idx+2], cfg_m[4*idx+1], cfg_m[4*idx]};
    else if (is_addr) old = addr_m[idx];
    case (op)
      RS:      cand = old | wd;
      RC:      cand = old & ~wd;
      default: cand = wd;
    endcase
    if (!r && acc) begin
      if (!legal) sb.push_back('{1'b1, 32'h0, cyc + 1});
      else if (re) sb.push_back('{1'b0, old, cyc + 1});
      if (legal && wr) begin
        if (is_cfg) begin
          for (int j = 0; j < 4; j++) ncfg[4*idx+j] = m_cfg(cfg_m[4*idx+j], cand[8*j +: 8]);
        end else if (!m_locked(idx)) begin
          naddr[idx] = cand;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      cfg_m[i]  = r ? 8'h00 : ncfg[i];
      addr_m[i] = r ? 32'h0 : naddr[i];
    end
  endtask

  initial begin : monitor
    resp_t rp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.csr_rvalid || bus.csr_illegal) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: rvalid=%0b illegal=%0b, expected no response (cycle %0d)",
                     bus.csr_rvalid, bus.csr_illegal, cyc);
          end else begin
            rp = sb.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(rp.due));
            chk("resp_illegal", 32'(bus.csr_illegal), 32'(rp.ill));
            chk("resp_rvalid", 32'(bus.csr_rvalid), 32'(!rp.ill));
            if (!rp.ill) chk("rdata", bus.csr_rdata, rp.data);
          end
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
          checks++; errors++;
          $display("FAIL missed_resp: got no pulse, expected illegal=%0b data=%h due cycle %0d",
                   sb[0].ill, sb[0].data, sb[0].due);
          void'(sb.pop_front());
        end
        for (int i = 0; i < 4; i++)
          chk($sformatf("pmpcfg%0d", i), cfg_o[i],
              {cfg_m[4*i+3], cfg_m[4*i+2], cfg_m[4*i+1], cfg_m[4*i]});
        for (int i = 0; i < 16; i++)
          chk($sformatf("pmpaddr%0d", i), addr_o[i], addr_m[i]);
      end
    end
  end

  initial begin : stimulus
    logic [11:0] a;
    logic [31:0] wd;
    logic [1:0]  pv;
    step(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 2'b11);
    mon_en = 1'b1;
    chk("reset_rdata", bus.csr_rdata, 32'h0);
    chk("reset_rvalid", 32'(bus.csr_rvalid), 32'h0);
    chk("reset_illegal", 32'(bus.csr_illegal), 32'h0);

    step(1'b0, 1'b1, 1'b0, RW, 12'h3A0, 32'h0F0D0B09, 2'b11);
    chk("tp_cfg0_rw", cfg_o[0], 32'h0F0D0B09);
    step(1'b0, 1'b0, 1'b1, 2'b00, 12'h3A0, 32'h0, 2'b11);
    chk("tp_read_rvalid", 32'(bus.csr_rvalid), 32'h1);
    chk("tp_read_rdata", bus.csr_rdata, 32'h0F0D0B09);

    step(1'b0, 1'b1, 1'b0, RW, 12'h3A0, 32'h00000062, 2'b11);
    chk("tp_warl_rw", cfg_o[0], 32'h0);

    step(1'b0, 1'b1, 1'b0, RW, 12'h3A0, 32'h00000089, 2'b11);
    chk("tp_lock_set", cfg_o[0], 32'h89);
    step(1'b0, 1'b1, 1'b0, RW, 12'h3B0, 32'h1234, 2'b11);
    chk("tp_lock_addr0", addr_o[0], 32'h0);
    chk("tp_lock_no_ill", 32'(bus.csr_illegal), 32'h0);
    step(1'b0, 1'b1, 1'b0, RC, 12'h3A0, 32'hFF, 2'b11);
    chk("tp_lock_rc", cfg_o[0], 32'h89);
    chk("tp_lock_rc_no_ill", 32'(bus.csr_illegal), 32'h0);

    step(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 2'b11);
    step(1'b0, 1'b1, 1'b0, RW, 12'h3A0, 32'h00008800, 2'b11);
    chk("tp_tor_cfg", cfg_o[0], 32'h00008800);
    step(1'b0, 1'b1, 1'b0, RW, 12'h3B0, 32'h5555, 2'b11);
    chk("tp_tor_addr0", addr_o[0], 32'h0);
    step(1'b0, 1'b1, 1'b0, RW, 12'h3B2, 32'h5555, 2'b11);
    chk("tp_tor_addr2", addr_o[2], 32'h5555);

    step(1'b0, 1'b1, 1'b0, RW, 12'h3B3, 32'hFFFF, 2'b00);
    chk("tp_umode_ill", 32'(bus.csr_illegal), 32'h1);
    chk("tp_umode_rvalid", 32'(bus.csr_rvalid), 32'h0);
    chk("tp_umode_addr3", addr_o[3], 32'h0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 12'h3C0, 32'h0, 2'b11);
    chk("tp_badaddr_ill", 32'(bus.csr_illegal), 32'h1);

    step(1'b0, 1'b1, 1'b0, RW, 12'h3B5, 32'h10, 2'b11);
    step(1'b0, 1'b1, 1'b1, RS, 12'h3B5, 32'h01, 2'b11);
    chk("tp_rbw_rvalid", 32'(bus.csr_rvalid), 32'h1);
    chk("tp_rbw_rdata", bus.csr_rdata, 32'h10);
    chk("tp_rbw_addr5", addr_o[5], 32'h11);

    step(1'b1, 1'b1, 1'b1, RW, 12'h3B6, 32'hABCD, 2'b11);
    for (int i = 0; i < 4; i++) chk("tp_rst_cfg", cfg_o[i], 32'h0);
    for (int i = 0; i < 16; i++) chk("tp_rst_addr", addr_o[i], 32'h0);
    chk("tp_rst_rdata", bus.csr_rdata, 32'h0);
    chk("tp_rst_rvalid", 32'(bus.csr_rvalid), 32'h0);
    chk("tp_rst_illegal", 32'(bus.csr_illegal), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    a = 12'h3A0 + 12'($urandom_range(0, 3));
        3, 4, 5, 6, 7: a = 12'h3B0 + 12'($urandom_range(0, 15));
        8:          a = 12'($urandom);
        default:    a = 12'h3A4 + 12'($urandom_range(0, 11));
      endcase
      wd = $urandom;
      if ($urandom_range(0, 7) != 0) wd = wd & 32'h7F7F7F7F;
      pv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      step($urandom_range(0, 149) == 0, 1'($urandom), 1'($urandom), 2'($urandom), a, wd, pv);
    end

    step(1'b0, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 2'b11);
    step(1'b0, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 2'b11);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmp_csr_file.md
Name: pmp_csr_file

Overview:
- M-mode CSR storage for RISC-V physical memory protection: pmpcfg0..3 and pmpaddr0..15.
- Accepts CSR read, write, set and clear accesses from the pipeline's CSR stage.
- Applies WARL legalisation and lock (L-bit) rules before storing any value.
- Drives the stored values continuously to the PMP address/permission checker, which is the consumer of this block's outputs.

Parameters:
- NUM_ENTRIES, 16: number of implemented PMP entries (1..16). Unimplemented entries have their cfg byte and pmpaddr hardwired to 0, writes to them are ignored, and reads return 0.
- NA4_EN, 1: when 0, a write of A=2'b10 (NA4) is not legal, and that entry's stored A field keeps its old value.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- csr_addr  input  12  CSR address
- csr_we  input  1  write request, qualified by csr_op
- csr_re  input  1  read request
- csr_op  input  2  01=RW, 10=RS (set), 11=RC (clear), 00=no write
- csr_wdata  input  32  write operand
- priv_mode  input  2  current privilege: 00=U, 01=S, 11=M
- csr_rdata  output  32  registered read data
- csr_rvalid  output  1  one-cycle pulse; csr_rdata is valid
- csr_illegal  output  1  one-cycle pulse; the access was illegal
- pmpcfg0_data..pmpcfg3_data  output  32 each  packed cfg bytes; entry 4k+j occupies bits [8j+7:8j]
- pmpaddr0_data..pmpaddr15_data  output  32 each  entry address (addr[33:2])

Behaviour:
- Reset (rst=1 on a clk edge):
  - All cfg bytes, all pmpaddr values, csr_rdata, csr_rvalid and csr_illegal clear to 0.
  - Reset is the only way to clear an L bit.
  - A reset asserted in the same cycle as a request discards that request; no pulse follows.
- Address map: 0x3A0–0x3A3 select pmpcfg0–3; 0x3B0–0x3BF select pmpaddr0–15.
- Access legality: an access (csr_we with csr_op≠00, or csr_re) is illegal when either holds:
  - csr_addr is outside the map above;
  - priv_mode≠2'b11.
- Illegal access effects:
  - csr_illegal pulses 1 on the next cycle.
  - csr_rvalid stays 0.
  - No state changes.
- Read timing and ordering:
  - Read latency is 1 cycle: csr_rdata and csr_rvalid are registered.
  - csr_rvalid pulses the cycle after csr_re is accepted.
  - When a read and a write target the same CSR in the same cycle, the read returns the pre-write value (read-before-write, as required by csrrw/csrrs).
- Write operand: candidate = wdata (RW), old|wdata (RS), old&~wdata (RC). The candidate is then legalised per entry as below.
- Cfg byte legalisation, applied to each of the 4 bytes independently:
  - If the stored L bit is 1, the byte is unchanged.
  - Bits [6:5] are reserved and always store 0.
  - If the candidate has R=0 and W=1, store R=0, W=0, and keep X, A and L from the candidate.
  - If the candidate has A=2'b10 and NA4_EN=0, the A field keeps its old value.
- pmpaddr i write is silently ignored (not illegal) in either case:
  - cfg i has L=1;
  - i<15 and cfg i+1 has L=1 and A=2'b01 (TOR).
- Output update: all outputs reflect the new stored values on the cycle after the write edge; no additional latency.
- Simultaneous csr_we and csr_re are legal. If the access is illegal, only csr_illegal pulses.
- The block never stalls; a new request is accepted every cycle.

Test Plan:
- Reset, then M-mode RW of 0x3A0 with wdata=0x0F0D0B09 → pmpcfg0_data=0x0F0D0B09. Read of 0x3A0 → csr_rvalid pulses 1 cycle later with rdata=0x0F0D0B09.
- M-mode RW of 0x3A0 with wdata=0x00000062 (bits[6:5] set, R=0, W=1) → stored byte 0x00.
- Write cfg0=0x89 (L=1, A=TOR, R=1), then RW pmpaddr0=0x1234 and RC of 0x3A0 with 0xFF → pmpaddr0 and cfg0 are unchanged and csr_illegal stays 0.
- Write cfg1 byte=0x88 (L=1, A=TOR), then RW pmpaddr0=0x5555 → pmpaddr0 is unchanged. RW pmpaddr2=0x5555 → pmpaddr2=0x5555.
- priv_mode=00, RW 0x3B3 with 0xFFFF → csr_illegal pulses next cycle and pmpaddr3 stays 0. In M-mode, an access to 0x3C0 → csr_illegal pulses.
- pmpaddr5=0x10, then the same cycle carries csr_re plus RS 0x3B5 with wdata=0x01 → rdata=0x10 and pmpaddr5=0x11. Asserting rst during a pending write → all outputs read 0.
